// File: rtl/exu_div_ctrl.sv
// Sequencer between EXU issue and the iterative divider: resolves divide-by-zero and
// signed overflow locally, otherwise launches exu_div. Optional result cache: DIV_RESULT_CACHE_EN.
module exu_div_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_w,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic             div_valid,
  input  logic             div_ready,
  output logic             div_flush,
  output logic             div_w,
  output logic [1:0]       div_signed,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic             div_out_valid,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder
);

  localparam int unsigned WW = 32;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic               w_q;
  logic [TAG_W-1:0]   tag_q;
  logic [XLEN-1:0]    src1_q;
  logic [XLEN-1:0]    src2_q;
  logic [XLEN-1:0]    res_data_q;
  logic               res_valid_q;
  logic               div_valid_q;
  logic [1:0]         div_signed_q;

  logic               accept;
  logic               req_signed;
  logic               is_zero;
  logic               is_int_min;
  logic               is_neg1;
  logic               is_ovf;
  logic               fast;
  logic [XLEN-1:0]    fast_q;
  logic [XLEN-1:0]    fast_r;
  logic               cache_hit;
  logic [XLEN-1:0]    cache_q;
  logic [XLEN-1:0]    cache_r;

  // Quotient vs remainder select, with sign extension of the low word for W ops.
  function automatic logic [XLEN-1:0] pick(input logic [1:0] op, input logic w,
                                           input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
    logic [XLEN-1:0] x;
    x = op[1] ? r : q;
    return w ? {{(XLEN-WW){x[WW-1]}}, x[WW-1:0]} : x;
  endfunction

  assign req_ready  = rst_n & (state == IDLE) & ~flush;
  assign accept     = req_valid & req_ready;
  assign req_signed = ~req_op[0];

  // Special-case detection on the operand width selected by req_w.
  assign is_zero    = req_w ? (req_src2[WW-1:0] == '0) : (req_src2 == '0);
  assign is_int_min = req_w ? (req_src1[WW-1:0] == {1'b1, {(WW-1){1'b0}}})
                            : (req_src1 == {1'b1, {(XLEN-1){1'b0}}});
  assign is_neg1    = req_w ? (&req_src2[WW-1:0]) : (&req_src2);
  assign is_ovf     = req_signed & is_int_min & is_neg1;
  assign fast       = is_zero | is_ovf;

  // Zero wins over overflow; the overflow quotient carries INT_MIN in the active width.
  always_comb begin
    fast_q = '1;
    fast_r = req_src1;
    if (!is_zero) begin
      fast_q = req_w ? {{(XLEN-WW){1'b1}}, 1'b1, {(WW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      fast_r = '0;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  logic            c_vld;
  logic [XLEN-1:0] c_src1;
  logic [XLEN-1:0] c_src2;
  logic            c_sgn;
  logic            c_w;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_r;

  assign cache_hit = c_vld & (c_src1 == req_src1) & (c_src2 == req_src2) &
                     (c_sgn == req_signed) & (c_w == req_w);
  assign cache_q   = c_q;
  assign cache_r   = c_r;

  // Filled only by a divider result that actually completes (flush wins over capture).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld  <= 1'b0;
      c_src1 <= '0;
      c_src2 <= '0;
      c_sgn  <= 1'b0;
      c_w    <= 1'b0;
      c_q    <= '0;
      c_r    <= '0;
    end else if (!flush && state == WAIT && div_out_valid) begin
      c_vld  <= 1'b1;
      c_src1 <= src1_q;
      c_src2 <= src2_q;
      c_sgn  <= ~op_q[0];
      c_w    <= w_q;
      c_q    <= div_quotient;
      c_r    <= div_remainder;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_q   = '0;
  assign cache_r   = '0;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      w_q          <= 1'b0;
      tag_q        <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      div_valid_q  <= 1'b0;
      div_signed_q <= '0;
    end else if (flush) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
      div_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q         <= req_op;
            w_q          <= req_w;
            tag_q        <= req_tag;
            src1_q       <= req_src1;
            src2_q       <= req_src2;
            div_signed_q <= req_signed ? 2'b11 : 2'b00;
            if (fast) begin
              res_data_q  <= pick(req_op, req_w, fast_q, fast_r);
              res_valid_q <= 1'b1;
              state       <= DONE;
            end else if (cache_hit) begin
              res_data_q  <= pick(req_op, req_w, cache_q, cache_r);
              res_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              div_valid_q <= 1'b1;
              state       <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (div_ready) begin
            div_valid_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (div_out_valid) begin
            res_data_q  <= pick(op_q, w_q, div_quotient, div_remainder);
            res_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_tag      = tag_q;
  assign busy         = (state != IDLE);
  assign div_valid    = div_valid_q;
  assign div_flush    = flush;
  assign div_w        = w_q;
  assign div_signed   = div_signed_q;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;

endmodule

// File: tb/tb_exu_div_ctrl.sv
// Directed bench for exu_div_ctrl with a behavioural fixed-latency divider.
// Cache expectations follow DIV_RESULT_CACHE_EN.
module tb_exu_div_ctrl;

  localparam int DIV_LAT = 12;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_ready, req_w;
  logic [1:0]  req_op;
  logic [4:0]  req_tag, res_tag;
  logic [63:0] req_src1, req_src2, res_data;
  logic        res_valid, res_ready, busy;
  logic        div_valid, div_ready, div_flush, div_w, div_out_valid;
  logic [1:0]  div_signed;
  logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;

  logic [63:0] m_q, m_r;
  int          m_cnt;
  logic        dov_pulse, spur, dov_prev;
  int          launches;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  exu_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
    .req_tag(req_tag), .req_src1(req_src1), .req_src2(req_src2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .busy(busy), .div_valid(div_valid), .div_ready(div_ready), .div_flush(div_flush),
    .div_w(div_w), .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_out_valid(div_out_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                           input logic sgn, input logic w);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sa32, sb32;
    int unsigned     ua32, ub32;
    logic [63:0]     q, r;
    if (w) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      q = sgn ? {32'h0, 32'(sa32 / sb32)} : {32'h0, ua32 / ub32};
      r = sgn ? {32'h0, 32'(sa32 % sb32)} : {32'h0, ua32 % ub32};
    end else begin
      sa = a; sb = b; ua = a; ub = b;
      q = sgn ? 64'(sa / sb) : ua / ub;
      r = sgn ? 64'(sa % sb) : ua % ub;
    end
    return {q, r};
  endfunction

  // Divider model: fixed latency, single out_valid pulse, cancelled by div_flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; dov_pulse <= 1'b0; launches <= 0; dov_prev <= 1'b0;
      m_q <= '0; m_r <= '0;
    end else begin
      dov_pulse <= 1'b0;
      dov_prev  <= div_out_valid;
      if (div_flush) m_cnt <= 0;
      else if (div_valid && div_ready) begin
        {m_q, m_r} <= ref_div(div_dividend, div_divisor, div_signed[0], div_w);
        m_cnt      <= DIV_LAT;
        launches   <= launches + 1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) dov_pulse <= 1'b1;
      end
    end
  end

  assign div_out_valid = dov_pulse | spur;
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic w, input logic [4:0] tag,
                       input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("issue_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_w = w; req_tag = tag; req_src1 = a; req_src2 = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 200) begin tick(); cyc++; end
    if (!res_valid) check("res_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic consume;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int cyc, l0;
    logic saw;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_w = 1'b0;
    req_tag = '0; req_src1 = '0; req_src2 = '0; res_ready = 1'b0; div_ready = 1'b1; spur = 1'b0;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_div_valid", 64'(div_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // DIVU 100/7 with the divider stalling acceptance for three cycles.
    div_ready = 1'b0;
    issue(OP_DIVU, 1'b0, 5'd3, 64'd100, 64'd7);
    check("divu_div_valid", 64'(div_valid), 64'd1);
    check("divu_signed", 64'(div_signed), 64'd0);
    check("divu_dividend", div_dividend, 64'd100);
    repeat (3) tick();
    check("divu_hold_valid", 64'(div_valid), 64'd1);
    div_ready = 1'b1;
    tick();
    check("divu_valid_drop", 64'(div_valid), 64'd0);
    wait_res(cyc);
    check("divu_data", res_data, 64'd14);
    check("divu_tag", 64'(res_tag), 64'd3);
    check("divu_after_dov", 64'(dov_prev), 64'd1);
    consume();

    // Divide by zero: fast path.
    l0 = launches;
    issue(OP_DIV, 1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0);
    wait_res(cyc);
    check("div0_lat", 64'(cyc), 64'd0);
    check("div0_data", res_data, 64'hFFFF_FFFF_FFFF_FFFF);
    consume();
    issue(OP_REM, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0);
    wait_res(cyc);
    check("rem0_data", res_data, 64'hFFFF_FFFF_FFFF_FFF9);
    consume();
    issue(OP_REMU, 1'b1, 5'd6, 64'hABCD_0000_0000_0005, 64'h1234_0000_0000_0000);
    wait_res(cyc);
    check("remuw0_data", res_data, 64'd5);
    consume();

    // Signed overflow, W and full width.
    issue(OP_DIV, 1'b1, 5'd8, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    wait_res(cyc);
    check("divw_ovf_lat", 64'(cyc), 64'd0);
    check("divw_ovf_data", res_data, 64'hFFFF_FFFF_8000_0000);
    consume();
    issue(OP_REM, 1'b1, 5'd9, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    wait_res(cyc);
    check("remw_ovf_lat", 64'(cyc), 64'd0);
    check("remw_ovf_data", res_data, 64'd0);
    consume();
    issue(OP_DIV, 1'b0, 5'd12, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_res(cyc);
    check("div_ovf_data", res_data, 64'h8000_0000_0000_0000);
    consume();
    check("fast_no_launch", 64'(launches - l0), 64'd0);

    // W divider path must sign-extend the low word (-20/3 = -6).
    issue(OP_DIV, 1'b1, 5'd13, 64'h1234_5678_FFFF_FFEC, 64'd3);
    wait_res(cyc);
    check("divw_data", res_data, 64'hFFFF_FFFF_FFFF_FFFA);
    consume();

    // Spurious out_valid while idle is ignored.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    check("spur_res_valid", 64'(res_valid), 64'd0);
    check("spur_busy", 64'(busy), 64'd0);

    // Flush 10 cycles into WAIT.
    issue(OP_DIVU, 1'b0, 5'd14, 64'd1000, 64'd3);
    repeat (11) tick();
    flush = 1'b1;
    #1;
    check("flush_div_flush", 64'(div_flush), 64'd1);
    check("flush_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_idle", 64'(busy), 64'd0);
    saw = 1'b0;
    repeat (20) begin
      saw = saw | res_valid;
      tick();
    end
    check("flush_no_res", 64'(saw), 64'd0);
    issue(OP_REMU, 1'b0, 5'd15, 64'd9, 64'd4);
    wait_res(cyc);
    check("remu_data", res_data, 64'd1);
    check("remu_tag", 64'(res_tag), 64'd15);
    consume();

    // Held result under backpressure.
    issue(OP_DIV, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    check("div_signed", 64'(div_signed), 64'd3);
    wait_res(cyc);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data", res_data, 64'hFFFF_FFFF_FFFF_FFFA);
      check("hold_tag", 64'(res_tag), 64'd7);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    consume();
    check("consumed_valid", 64'(res_valid), 64'd0);
    check("consumed_ready", 64'(req_ready), 64'd1);

    // Flush together with res_ready in DONE.
    issue(OP_DIVU, 1'b0, 5'd16, 64'd1, 64'd0);
    flush = 1'b1; res_ready = 1'b1;
    tick();
    flush = 1'b0; res_ready = 1'b0;
    check("flush_done_valid", 64'(res_valid), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd0);

    // Repeated operands: cache hit when enabled, divider otherwise.
    issue(OP_DIV, 1'b0, 5'd10, 64'd100, 64'd7);
    wait_res(cyc);
    check("cache_div_data", res_data, 64'd14);
    consume();
    l0 = launches;
    issue(OP_REM, 1'b0, 5'd11, 64'd100, 64'd7);
    wait_res(cyc);
    check("cache_rem_data", res_data, 64'd2);
    check("cache_rem_tag", 64'(res_tag), 64'd11);
`ifdef DIV_RESULT_CACHE_EN
    check("cache_hit_lat", 64'(cyc), 64'd0);
    check("cache_hit_launch", 64'(launches - l0), 64'd0);
`else
    check("nocache_launch", 64'(launches - l0), 64'd1);
`endif
    consume();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
